hidden_layer_sampler: RTL and testbench

//  Up-pass (visible->hidden) engine of the RBM, the opposite direction of the reconstruct path.

---
 rtl/rbm_pkg.sv | 22 ++
 rtl/rbm_lfsr16.sv | 26 ++
 rtl/hidden_layer_sampler.sv | 142 ++++++++++++++
 tb/tb_hidden_layer_sampler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rbm_pkg.sv
// Shared RBM definitions: FSM encodings used by both Gibbs half-steps,
// accumulator sizing and the LFSR polynomial/seed.
package rbm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_MAC     = 3'b001,
    ST_BIAS    = 3'b010,
    ST_SIGMOID = 3'b011,
    ST_COMPARE = 3'b100,
    ST_DONE    = 3'b110
  } rbm_state_e;

  // x^16+x^14+x^13+x^11+1 on a left-shifting register -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic int acc_w(input int n, input int nv);
    return n + $clog2(nv) + 1;
  endfunction

endpackage

// File: rtl/rbm_lfsr16.sv
// 16-bit Fibonacci LFSR, shifts left with feedback into bit 0 on each adv.
module rbm_lfsr16
  import rbm_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        adv,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (adv) q_d = {q_q[14:0], ^(q_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) q_q <= seed;
    else          q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/hidden_layer_sampler.sv
// RBM up-pass: per hidden unit, MAC over the binary visible vector, add bias,
// hard sigmoid, then sample against a fixed or LFSR threshold.
module hidden_layer_sampler
  import rbm_pkg::*;
#(
  parameter int          NV            = 16,
  parameter int          NH            = 16,
  parameter int          N             = 8,
  parameter int          FRAC_SH       = 2,
  parameter int          DETERMINISTIC = 0,
  parameter logic [15:0] SEED          = LFSR_SEED
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic [NV-1:0]                    v_in,
  output logic                             w_rd_en,
  output logic [$clog2(NH)+$clog2(NV)-1:0] w_addr,
  input  logic [N-1:0]                     w_rdata,
  output logic [$clog2(NH)-1:0]            b_addr,
  input  logic [N-1:0]                     b_rdata,
  output logic                             system_done,
  output logic [NH-1:0]                    h_out,
  output logic [2:0]                       state_display
);

  localparam int JW = $clog2(NH);
  localparam int IW = $clog2(NV);
  localparam int KW = IW + 1;
  localparam int AW = acc_w(N, NV);

  rbm_state_e            state_q, state_d;
  logic [NV-1:0]         v_q, v_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [JW-1:0]         j_q, j_d;
  logic [KW-1:0]         k_q, k_d;
  logic [7:0]            p_q, p_d;
  logic [NH-1:0]         h_q, h_d;
  logic                  lfsr_adv;
  logic [15:0]           lfsr_q;

  logic signed [AW-1:0]  w_ext, b_ext, x;
  logic signed [AW:0]    s;
  logic [IW-1:0]         k_prev;
  logic [7:0]            thr;

  assign w_ext  = {{(AW-N){w_rdata[N-1]}}, w_rdata};
  assign b_ext  = {{(AW-N){b_rdata[N-1]}}, b_rdata};
  assign x      = acc_q >>> FRAC_SH;
  assign s      = {x[AW-1], x} + (AW+1)'(128);
  assign k_prev = IW'(k_q - KW'(1));
  assign thr    = (DETERMINISTIC != 0) ? 8'd128 : lfsr_q[7:0];

  rbm_lfsr16 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .adv     (lfsr_adv),
    .seed    (SEED),
    .q       (lfsr_q)
  );

  always_comb begin
    state_d  = state_q;
    v_d      = v_q;
    acc_d    = acc_q;
    j_d      = j_q;
    k_d      = k_q;
    p_d      = p_q;
    h_d      = h_q;
    w_rd_en  = 1'b0;
    lfsr_adv = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          v_d     = v_in;
          h_d     = '0;
          acc_d   = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        w_rd_en = (k_q < KW'(NV));
        // read data trails the address by one cycle, so slot k adds W[j][k-1]
        if (k_q != '0 && v_q[k_prev]) acc_d = acc_q + w_ext;
        k_d = k_q + KW'(1);
        if (k_q == KW'(NV)) state_d = ST_BIAS;
      end
      ST_BIAS: begin
        acc_d   = acc_q + b_ext;
        state_d = ST_SIGMOID;
      end
      ST_SIGMOID: begin
        if (s < 0)        p_d = 8'd0;
        else if (s > 255) p_d = 8'd255;
        else              p_d = s[7:0];
        state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        h_d[j_q] = (p_q > thr);
        lfsr_adv = (DETERMINISTIC == 0);
        if (j_q == JW'(NH-1)) begin
          state_d = ST_DONE;
        end else begin
          j_d     = j_q + JW'(1);
          acc_d   = '0;
          k_d     = '0;
          state_d = ST_MAC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      v_q     <= '0;
      acc_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      p_q     <= '0;
      h_q     <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      acc_q   <= acc_d;
      j_q     <= j_d;
      k_q     <= k_d;
      p_q     <= p_d;
      h_q     <= h_d;
    end
  end

  assign w_addr        = {j_q, k_q[IW-1:0]};
  assign b_addr        = j_q;
  assign system_done   = (state_q == ST_DONE);
  assign h_out         = h_q;
  assign state_display = state_q;

endmodule

// File: tb/tb_hidden_layer_sampler.sv
// Directed bench: a deterministic instance (FRAC_SH=0) and a stochastic one
// (FRAC_SH=2) share stimulus and weight/bias memories.
module tb_hidden_layer_sampler;

  localparam int NV = 16;
  localparam int NH = 16;
  localparam int LAT = NH * (NV + 4);
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [NV-1:0] v_in;

  logic       w_rd_en_det, w_rd_en_sto;
  logic [7:0] w_addr_det, w_addr_sto;
  logic [7:0] w_rdata_det, w_rdata_sto;
  logic [3:0] b_addr_det, b_addr_sto;
  logic [7:0] b_rdata_det, b_rdata_sto;
  logic       done_det, done_sto;
  logic [NH-1:0] h_det, h_sto;
  logic [2:0] st_det, st_sto;

  logic [7:0] wmem [NH][NV];
  logic [7:0] bmem [NH];
  logic [15:0] lf_m;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hidden_layer_sampler #(.NV(NV), .NH(NH), .N(8), .FRAC_SH(0), .DETERMINISTIC(1), .SEED(SEED)) dut_det (
    .clk(clk), .reset_n(reset_n), .start(start), .v_in(v_in),
    .w_rd_en(w_rd_en_det), .w_addr(w_addr_det), .w_rdata(w_rdata_det),
    .b_addr(b_addr_det), .b_rdata(b_rdata_det),
    .system_done(done_det), .h_out(h_det), .state_display(st_det)
  );

  hidden_layer_sampler #(.NV(NV), .NH(NH), .N(8), .FRAC_SH(2), .DETERMINISTIC(0), .SEED(SEED)) dut_sto (
    .clk(clk), .reset_n(reset_n), .start(start), .v_in(v_in),
    .w_rd_en(w_rd_en_sto), .w_addr(w_addr_sto), .w_rdata(w_rdata_sto),
    .b_addr(b_addr_sto), .b_rdata(b_rdata_sto),
    .system_done(done_sto), .h_out(h_sto), .state_display(st_sto)
  );

  // Synchronous memories; idle read data is junk so stray use of it shows up.
  always @(posedge clk) begin
    w_rdata_det <= w_rd_en_det ? wmem[w_addr_det[7:4]][w_addr_det[3:0]] : 8'($urandom);
    w_rdata_sto <= w_rd_en_sto ? wmem[w_addr_sto[7:4]][w_addr_sto[3:0]] : 8'($urandom);
    b_rdata_det <= bmem[b_addr_det];
    b_rdata_sto <= bmem[b_addr_sto];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [NV-1:0] v, input int fsh, input bit det,
                       inout logic [15:0] lf, output logic [NH-1:0] h);
    for (int j = 0; j < NH; j++) begin
      int acc, p;
      logic [7:0] r;
      acc = int'($signed(bmem[j]));
      for (int i = 0; i < NV; i++)
        if (v[i]) acc += int'($signed(wmem[j][i]));
      p = (acc >>> fsh) + 128;
      if (p < 0)   p = 0;
      if (p > 255) p = 255;
      r = det ? 8'd128 : lf[7:0];
      h[j] = (p > int'(r));
      if (!det) lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
    end
  endtask

  task automatic fill(input int wv, input int bv, input bit rnd);
    for (int j = 0; j < NH; j++) begin
      bmem[j] = rnd ? 8'($urandom) : 8'(bv);
      for (int i = 0; i < NV; i++) wmem[j][i] = rnd ? 8'($urandom) : 8'(wv);
    end
  endtask

  task automatic go(input logic [NV-1:0] v);
    @(negedge clk);
    v_in  = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mac_entry", 32'(st_det), 32'h1);
  endtask

  // Call after go; skip = cycles already consumed since the start edge beyond go.
  task automatic finish_run(input string tag, input int skip, input logic [NV-1:0] v,
                            input logic [NH-1:0] exp_det);
    logic [NH-1:0] e_sto;
    logic [15:0] dummy;
    repeat (LAT - 1 - skip) @(negedge clk);
    chk({tag, "_done_early"}, 32'({done_det, done_sto}), 32'h0);
    @(negedge clk);
    chk({tag, "_done_lat"}, 32'({done_det, done_sto}), 32'h3);
    chk({tag, "_st_done"}, 32'(st_det), 32'h6);
    chk({tag, "_h_det"}, 32'(h_det), 32'(exp_det));
    model(v, 2, 1'b0, lf_m, e_sto);
    chk({tag, "_h_sto"}, 32'(h_sto), 32'(e_sto));
    dummy = 16'h0;
    model(v, 0, 1'b1, dummy, e_sto);
    chk({tag, "_h_det_model"}, 32'(h_det), 32'(e_sto));
  endtask

  initial begin
    logic [NH-1:0] e;
    logic [15:0]   dummy;
    logic [NV-1:0] vr;
    reset_n = 1'b0;
    start   = 1'b0;
    v_in    = '0;
    lf_m    = SEED;
    fill(0, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_state", 32'({st_det, st_sto}), 32'h0);
    chk("rst_h", 32'({h_det, h_sto}), 32'h0);
    chk("rst_ctl", 32'({done_det, w_rd_en_det, w_addr_det, b_addr_det}), 32'h0);
    reset_n = 1'b1;

    // T1: zero weights/bias -> p=128, not above 128
    go(16'hFFFF);
    finish_run("t1", 0, 16'hFFFF, 16'h0000);
    chk("t1_h_stable", 32'(h_det), 32'h0);

    // T2: W=+1 -> acc=16, p=144
    fill(1, 0, 1'b0);
    go(16'hFFFF);
    finish_run("t2", 0, 16'hFFFF, 16'hFFFF);

    // T3: saturation at both ends
    fill(127, 127, 1'b0);
    go(16'hFFFF);
    finish_run("t3_hi", 0, 16'hFFFF, 16'hFFFF);
    fill(-128, -128, 1'b0);
    go(16'hFFFF);
    finish_run("t3_lo", 0, 16'hFFFF, 16'h0000);
    chk("t3_lo_sto_const", 32'(h_sto), 32'h0);

    // T4: v=0, random weights must not leak into acc; bias alternates +5/-5
    fill(0, 0, 1'b1);
    for (int j = 0; j < NH; j++) bmem[j] = (j % 2 == 0) ? 8'sd5 : -8'sd5;
    go(16'h0000);
    finish_run("t4", 0, 16'h0000, 16'h5555);

    // T5a: start pulse plus v_in change mid-MAC is ignored
    fill(1, 0, 1'b0);
    go(16'hFFFF);
    repeat (5) @(negedge clk);
    v_in  = 16'h0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_run("t5_busy", 6, 16'hFFFF, 16'hFFFF);

    // T5b: reset at cycle 50 of a run returns everything to reset values
    fill(-128, -128, 1'b0);
    go(16'hFFFF);
    repeat (49) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_state", 32'({st_det, st_sto}), 32'h0);
    chk("t5_rst_h", 32'({h_det, h_sto}), 32'h0);
    chk("t5_rst_ctl", 32'({done_det, done_sto, w_rd_en_det, w_addr_det, b_addr_det}), 32'h0);
    lf_m = SEED;
    @(negedge clk);
    reset_n = 1'b1;
    fill(1, 0, 1'b0);
    go(16'hFFFF);
    finish_run("t5_rerun", 0, 16'hFFFF, 16'hFFFF);

    // T6: random W/b/v, two back-to-back runs continue the LFSR sequence
    for (int run = 0; run < 2; run++) begin
      fill(0, 0, 1'b1);
      vr = 16'($urandom);
      dummy = 16'h0;
      model(vr, 0, 1'b1, dummy, e);
      go(vr);
      finish_run($sformatf("t6_run%0d", run), 0, vr, e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
